idiv_int_div_iter: RTL and testbench

IDIV_INT_DIV_ITER -- requirements
Module: idiv_int_div_iter

---
 rtl/idiv_int_div_iter_if.sv | 20 ++
 rtl/idiv_int_div_iter.sv | 86 ++++++++
 tb/tb_idiv_int_div_iter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/idiv_int_div_iter_if.sv
// Request/response stream bundle for the iterative 32-bit unsigned divider.
// The divider sits on the slave side and the requester/consumer on the master side.
interface idiv_int_div_iter_if;
  logic        istream_val;
  logic        istream_rdy;
  logic [63:0] istream_msg;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [63:0] ostream_msg;

  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );

  modport master (
    output istream_val, istream_msg, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );
endinterface

// File: rtl/idiv_int_div_iter.sv
// Iterative 32-bit unsigned restoring divider: one quotient bit per cycle,
// 32 calculation cycles per request, and the response is held until it is consumed.
module idiv_int_div_iter (
  input  logic                 clk,
  input  logic                 reset,
  idiv_int_div_iter_if.slave   bus
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [5:0]          cnt_q;
  logic [DATA_W-1:0]   rem_q, quo_q, dvs_q;
  logic [DATA_W-1:0]   rem_d, quo_d;
  logic                irdy, oval;

  // The quotient register starts out holding the dividend; its MSB feeds the
  // remainder each step while the new quotient bit enters at the LSB.
  function automatic logic [2*DATA_W-1:0] div_step(
    input logic [DATA_W-1:0] rem,
    input logic [DATA_W-1:0] quo,
    input logic [DATA_W-1:0] dvs
  );
    logic signed [DATA_W+1:0] diff;
    diff = $signed({1'b0, rem, quo[DATA_W-1]}) - $signed({2'b00, dvs});
    if (diff[DATA_W+1])
      div_step = {rem[DATA_W-2:0], quo[DATA_W-1], quo[DATA_W-2:0], 1'b0};
    else
      div_step = {diff[DATA_W-1:0], quo[DATA_W-2:0], 1'b1};
  endfunction

  always_comb begin
    {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.istream_val) state_q <= CALC;
        CALC:    if (cnt_q == 6'd31) state_q <= DONE;
        DONE:    if (bus.ostream_rdy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath is always reloaded on acceptance, so it carries no reset.
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: begin
        if (bus.istream_val) begin
          quo_q <= bus.istream_msg[63:32];
          dvs_q <= bus.istream_msg[31:0];
          rem_q <= '0;
          cnt_q <= '0;
        end
      end
      CALC: begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q + 6'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (state_q)
      IDLE:    begin irdy = 1'b1; oval = 1'b0; end
      CALC:    begin irdy = 1'b0; oval = 1'b0; end
      DONE:    begin irdy = 1'b0; oval = 1'b1; end
      default: begin irdy = 1'bx; oval = 1'bx; end
    endcase
  end

  assign bus.istream_rdy = irdy;
  assign bus.ostream_val = oval;
  assign bus.ostream_msg = (state_q == DONE) ? {rem_q, quo_q} : 64'h0;
endmodule

// File: tb/tb_idiv_int_div_iter.sv
// Self-checking bench for idiv_int_div_iter: directed operand cases, backpressure,
// reset abort, pending-request behaviour and a randomized stream against a reference model.
module tb_idiv_int_div_iter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  idiv_int_div_iter_if bus_if ();

  idiv_int_div_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [63:0] req);
    logic [31:0] a, b;
    a = req[63:32];
    b = req[31:0];
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] msg);
    int n = 0;
    while (!bus_if.istream_rdy && n < 200) begin
      tick();
      n++;
    end
    check("send_rdy", {63'd0, bus_if.istream_rdy}, 64'd1);
    bus_if.istream_val = 1'b1;
    bus_if.istream_msg = msg;
    tick();
    bus_if.istream_val = 1'b0;
  endtask

  task automatic wait_resp(output logic [63:0] msg, output int edges);
    edges = 0;
    while (!bus_if.ostream_val && edges < 100) begin
      tick();
      edges++;
    end
    msg = bus_if.ostream_msg;
  endtask

  logic [63:0] dir_req [5];
  logic [63:0] dir_exp [5];

  initial begin
    logic [63:0] resp, req_a, req_b;
    int          edges;
    bit          seen;

    dir_req[0] = {32'd100, 32'd7};          dir_exp[0] = 64'h00000002_0000000E;
    dir_req[1] = {32'd5, 32'd0};            dir_exp[1] = 64'h00000005_FFFFFFFF;
    dir_req[2] = {32'hFFFFFFFF, 32'd1};     dir_exp[2] = 64'h00000000_FFFFFFFF;
    dir_req[3] = {32'd3, 32'd10};           dir_exp[3] = 64'h00000003_00000000;
    dir_req[4] = {32'h80000000, 32'hFFFFFFFF}; dir_exp[4] = 64'h80000000_00000000;

    reset = 1'b1;
    bus_if.istream_val = 1'b0;
    bus_if.istream_msg = '0;
    bus_if.ostream_rdy = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_irdy", {63'd0, bus_if.istream_rdy}, 64'd1);
    check("rst_oval", {63'd0, bus_if.ostream_val}, 64'd0);
    check("rst_omsg", bus_if.ostream_msg, 64'h0);

    // Directed operands with a consumer that is always ready
    for (int i = 0; i < 5; i++) begin
      send(dir_req[i]);
      check("calc_irdy", {63'd0, bus_if.istream_rdy}, 64'd0);
      check("calc_omsg", bus_if.ostream_msg, 64'h0);
      wait_resp(resp, edges);
      check("dir_latency", 64'(edges), 64'd32);
      check("dir_msg", resp, dir_exp[i]);
      tick();
      check("dir_post_oval", {63'd0, bus_if.ostream_val}, 64'd0);
      check("dir_post_irdy", {63'd0, bus_if.istream_rdy}, 64'd1);
    end

    // Backpressure: response must hold for 10 stalled cycles
    bus_if.ostream_rdy = 1'b0;
    send({32'd1000, 32'd33});
    wait_resp(resp, edges);
    check("bp_latency", 64'(edges), 64'd32);
    check("bp_msg", resp, 64'h0000000A_0000001E);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_msg", bus_if.ostream_msg, 64'h0000000A_0000001E);
      check("bp_hold_oval", {63'd0, bus_if.ostream_val}, 64'd1);
      check("bp_hold_irdy", {63'd0, bus_if.istream_rdy}, 64'd0);
    end
    bus_if.ostream_rdy = 1'b1;
    tick();
    check("bp_done_irdy", {63'd0, bus_if.istream_rdy}, 64'd1);
    check("bp_done_oval", {63'd0, bus_if.ostream_val}, 64'd0);

    // Reset mid-calculation, with a request presented during reset
    send({32'd100, 32'd7});
    repeat (10) tick();
    reset = 1'b1;
    bus_if.istream_val = 1'b1;
    bus_if.istream_msg = {32'd77, 32'd5};
    tick();
    reset = 1'b0;
    bus_if.istream_val = 1'b0;
    check("rstmid_irdy", {63'd0, bus_if.istream_rdy}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_if.ostream_val) seen = 1'b1;
    end
    check("rstmid_no_resp", {63'd0, seen}, 64'd0);

    // Request presented during CALC waits for IDLE; input changes do not disturb the result
    req_a = {32'd123456789, 32'd1000};
    req_b = {32'd999, 32'd4};
    send(req_a);
    repeat (3) tick();
    bus_if.istream_val = 1'b1;
    bus_if.istream_msg = {$urandom, $urandom};
    repeat (2) tick();
    bus_if.istream_msg = req_b;
    wait_resp(resp, edges);
    check("pend_a_msg", resp, ref_div(req_a));
    tick();
    check("pend_idle_irdy", {63'd0, bus_if.istream_rdy}, 64'd1);
    tick();
    bus_if.istream_val = 1'b0;
    check("pend_b_accepted", {63'd0, bus_if.istream_rdy}, 64'd0);
    wait_resp(resp, edges);
    check("pend_b_latency", 64'(edges), 64'd32);
    check("pend_b_msg", resp, ref_div(req_b));
    tick();

    // Randomized streaming against the reference model
    begin
      logic [63:0] exp_q[$];
      int sent = 0, got = 0, cyc = 0;
      bit in_fire, out_fire;
      logic [31:0] a, b;
      while (got < 500 && cyc < 60000) begin
        if (!bus_if.istream_val && sent < 500 && $urandom_range(0, 2) == 0) begin
          a = $urandom;
          case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'd1;
            2:       b = $urandom_range(1, 255);
            3:       b = a + 32'd1;
            default: b = $urandom;
          endcase
          bus_if.istream_val = 1'b1;
          bus_if.istream_msg = {a, b};
        end
        bus_if.ostream_rdy = ($urandom_range(0, 3) != 0);
        in_fire  = bus_if.istream_val && bus_if.istream_rdy;
        out_fire = bus_if.ostream_val && bus_if.ostream_rdy;
        if (out_fire) begin
          if (exp_q.size() == 0)
            check("rand_extra_resp", 64'd1, 64'd0);
          else
            check("rand_msg", bus_if.ostream_msg, exp_q.pop_front());
          got++;
        end
        if (in_fire) exp_q.push_back(ref_div(bus_if.istream_msg));
        tick();
        cyc++;
        if (in_fire) begin
          bus_if.istream_val = 1'b0;
          sent++;
        end
      end
      check("rand_count", 64'(got), 64'd500);
      check("rand_left", 64'(exp_q.size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
